hex_syscall_unit: RTL

- Sits directly downstream of the hex core's syscall outputs and services each SVC instruction the core issues.
- Decodes the syscall number and fetches the stack pointer and arguments through its own word-wide data-memory port.
- Performs the byte I/O handshake, or stores the read result back to the stack.
- Stalls the core until the call retires; EXIT halts the system.

---
 rtl/hex_pkg.sv | 17 +
 rtl/hex_syscall_unit_if.sv | 41 ++++
 rtl/hex_syscall_unit.sv | 151 +++++++++++++++
 3 files changed

// File: rtl/hex_pkg.sv
// Shared hex core definitions: syscall numbers and stack-frame layout
// used by the syscall unit.
package hex_pkg;

  typedef enum logic [1:0] {
    SYSCALL_EXIT  = 2'd0,
    SYSCALL_WRITE = 2'd1,
    SYSCALL_READ  = 2'd2,
    SYSCALL_RSVD  = 2'd3
  } syscall_t;

  localparam int unsigned SP_WORD_ADDR = 1;
  localparam int unsigned SYS_ARG0_OFS = 2;
  localparam int unsigned SYS_ARG1_OFS = 3;
  localparam int unsigned SYS_RES_OFS  = 1;

endpackage

// File: rtl/hex_syscall_unit_if.sv
// Syscall unit bus bundle: word-wide data-memory port plus the
// byte-wide tx/rx stream handshakes.
interface hex_syscall_unit_if #(
  parameter int ADDR_W = 19
);

  logic              m_valid;
  logic              m_we;
  logic [ADDR_W-1:0] m_addr;
  logic [31:0]       m_wdata;
  logic [31:0]       m_rdata;

  logic              tx_valid;
  logic [7:0]        tx_data;
  logic [7:0]        tx_stream;
  logic              tx_ready;

  logic              rx_ready;
  logic [7:0]        rx_stream;
  logic              rx_valid;
  logic [7:0]        rx_data;

  modport master (
    output m_valid, m_we, m_addr, m_wdata,
    input  m_rdata,
    output tx_valid, tx_data, tx_stream,
    input  tx_ready,
    output rx_ready, rx_stream,
    input  rx_valid, rx_data
  );

  modport slave (
    input  m_valid, m_we, m_addr, m_wdata,
    output m_rdata,
    input  tx_valid, tx_data, tx_stream,
    output tx_ready,
    input  rx_ready, rx_stream,
    output rx_valid, rx_data
  );

endinterface

// File: rtl/hex_syscall_unit.sv
// Services hex SVC instructions: loads sp/args, runs byte I/O, halts on EXIT.
// Define HEX_SYSCALL_CNT_EN to add saturating tx/rx handshake counters.
module hex_syscall_unit
  import hex_pkg::*;
#(
  parameter int ADDR_W  = 19,
  parameter int SP_ADDR = SP_WORD_ADDR
) (
  input  logic       i_clk,
  input  logic       i_rst_n,
  input  logic       i_syscall_valid,
  input  logic [1:0] i_syscall,
  output logic       o_stall,
  hex_syscall_unit_if.master bus,
  output logic       o_exit_valid,
  output logic [7:0] o_exit_code
`ifdef HEX_SYSCALL_CNT_EN
  ,
  output logic [15:0] o_tx_count,
  output logic [15:0] o_rx_count
`endif
);

  typedef enum logic [2:0] {
    IDLE, LD_A, LD_B, WAIT_B, TX, RX, DONE, HALT
  } state_t;

  state_t            state_q;
  syscall_t          num_q;
  logic [ADDR_W-1:0] sp_q;
  logic [7:0]        arg0_q;
  logic [7:0]        arg1_q;

  logic [ADDR_W-1:0] sp_in;
  logic              svc_go;
  logic              tx_fire;
  logic              rx_fire;
  logic              unused_rdata;

  assign sp_in   = bus.m_rdata[ADDR_W-1:0];
  assign svc_go  = i_rst_n & i_syscall_valid;
  assign tx_fire = (state_q == TX) & bus.tx_ready;
  assign rx_fire = (state_q == RX) & bus.rx_valid;
  assign unused_rdata = ^bus.m_rdata[31:8];

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      state_q <= IDLE;
      num_q   <= SYSCALL_EXIT;
      sp_q    <= '0;
      arg0_q  <= '0;
      arg1_q  <= '0;
    end else begin
      unique case (state_q)
        IDLE: if (i_syscall_valid) begin
          if (syscall_t'(i_syscall) == SYSCALL_RSVD) begin
            state_q <= DONE;
          end else begin
            num_q   <= syscall_t'(i_syscall);
            state_q <= LD_A;
          end
        end
        LD_A: begin
          sp_q    <= sp_in;
          state_q <= LD_B;
        end
        LD_B: begin
          arg0_q <= bus.m_rdata[7:0];
          unique case (num_q)
            SYSCALL_WRITE: state_q <= WAIT_B;
            SYSCALL_READ:  state_q <= RX;
            default:       state_q <= HALT;
          endcase
        end
        WAIT_B: begin
          arg1_q  <= bus.m_rdata[7:0];
          state_q <= TX;
        end
        TX:   if (bus.tx_ready) state_q <= DONE;
        RX:   if (bus.rx_valid) state_q <= DONE;
        DONE: state_q <= IDLE;
        HALT: state_q <= HALT;
        default: state_q <= IDLE;
      endcase
    end
  end

  // Request address for LD_A comes straight off the read bus, not sp_q.
  always_comb begin
    bus.m_valid = 1'b0;
    bus.m_we    = 1'b0;
    bus.m_addr  = '0;
    bus.m_wdata = '0;
    unique case (state_q)
      IDLE: if (svc_go && i_syscall != 2'd3) begin
        bus.m_valid = 1'b1;
        bus.m_addr  = ADDR_W'(SP_ADDR);
      end
      LD_A: begin
        bus.m_valid = 1'b1;
        bus.m_addr  = sp_in + ADDR_W'(SYS_ARG0_OFS);
      end
      LD_B: if (num_q == SYSCALL_WRITE) begin
        bus.m_valid = 1'b1;
        bus.m_addr  = sp_q + ADDR_W'(SYS_ARG1_OFS);
      end
      RX: if (bus.rx_valid) begin
        bus.m_valid = 1'b1;
        bus.m_we    = 1'b1;
        bus.m_addr  = sp_q + ADDR_W'(SYS_RES_OFS);
        bus.m_wdata = {24'b0, bus.rx_data};
      end
      default: ;
    endcase
  end

  assign bus.tx_valid  = (state_q == TX);
  assign bus.tx_data   = (state_q == TX) ? arg0_q : 8'h00;
  assign bus.tx_stream = (state_q == TX) ? arg1_q : 8'h00;
  assign bus.rx_ready  = (state_q == RX);
  assign bus.rx_stream = (state_q == RX) ? arg0_q : 8'h00;

  assign o_exit_valid = (state_q == HALT);
  assign o_exit_code  = (state_q == HALT) ? arg0_q : 8'h00;

  assign o_stall = i_rst_n &
                   ((state_q == HALT) |
                    ((state_q != DONE) & i_syscall_valid));

`ifdef HEX_SYSCALL_CNT_EN
  logic [15:0] tx_cnt_q;
  logic [15:0] rx_cnt_q;

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      tx_cnt_q <= '0;
      rx_cnt_q <= '0;
    end else begin
      if (tx_fire && tx_cnt_q != 16'hFFFF) tx_cnt_q <= tx_cnt_q + 16'd1;
      if (rx_fire && rx_cnt_q != 16'hFFFF) rx_cnt_q <= rx_cnt_q + 16'd1;
    end
  end

  assign o_tx_count = tx_cnt_q;
  assign o_rx_count = rx_cnt_q;
`else
  logic unused_fire;
  assign unused_fire = tx_fire ^ rx_fire;
`endif

endmodule
